// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
//   Shared definitions for the SimpleRisc programmable timer:
//   register map, CTRL/STATUS bit layout, and the controller FSM states.
// ---------------------------------------------------------------------------
package timer_pkg;

   // Word register map
   localparam int unsigned ADDR_CTRL   = 0;
   localparam int unsigned ADDR_LOAD   = 1;
   localparam int unsigned ADDR_COUNT  = 2;  // read-only
   localparam int unsigned ADDR_STATUS = 3;

   // CTRL bit positions
   localparam int unsigned CTRL_EN_BIT   = 0;
   localparam int unsigned CTRL_MODE_BIT = 1;
   localparam int unsigned CTRL_PSEL_LSB = 2;
   localparam int unsigned PSEL_W        = 3;
   localparam int unsigned CTRL_IE_BIT   = 5;
   localparam int unsigned CTRL_W        = 6;

   // STATUS bit positions
   localparam int unsigned STATUS_TIF_BIT = 0;

   // Packed view of CTRL[5:0]; field order matches the bit positions above.
   typedef struct packed {
      logic              ie;    // [5]
      logic [PSEL_W-1:0] psel;  // [4:2]
      logic              mode;  // [1] 0 one-shot, 1 periodic
      logic              en;    // [0]
   } ctrl_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// ---------------------------------------------------------------------------
// timer_prescaler
//   Synchronous prescaler: an up-counter that runs only while the timer is in
//   RUN and is otherwise held at zero. A tick is produced whenever the low
//   PSEL+1 bits of the counter are all ones, i.e. every 2^(PSEL+1) cycles.
//
//   clk   in   system clock, rising edge
//   rst   in   synchronous reset, active-low
//   run   in   timer is in RUN; enables counting and ticks
//   psel  in   divider select, divide-by 2^(psel+1)
//   tick  out  single-cycle count enable for the down-counter
// ---------------------------------------------------------------------------
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int unsigned PRESC_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [PSEL_W-1:0] psel,
   output logic              tick
);

   logic [PRESC_W-1:0] psc_q, psc_d;
   logic [PRESC_W-1:0] tap_mask;

   // Outside RUN the counter is forced to zero, so the first RUN cycle always
   // starts from 0 and the first tick lands exactly 2^(PSEL+1) cycles in.
   always_comb begin
      psc_d = '0;
      if (run) begin
         psc_d = psc_q + PRESC_W'(1);
      end
   end

   // Thermometer mask of the low PSEL+1 bits.
   always_comb begin
      tap_mask = '0;
      for (int unsigned i = 0; i < PRESC_W; i++) begin
         tap_mask[i] = (i <= 32'(psel));
      end
   end

   assign tick = run && ((psc_q & tap_mask) == tap_mask);

   always_ff @(posedge clk) begin
      if (!rst) begin
         psc_q <= '0;
      end else begin
         psc_q <= psc_d;
      end
   end

endmodule

// File: rtl/timer_ctrl.sv
// ---------------------------------------------------------------------------
// timer_ctrl
//   Programmable count-down timer for the SimpleRisc SoC. CPU-visible register
//   file (CTRL, LOAD, COUNT, STATUS), IDLE/RUN/DONE sequencing FSM, prescaled
//   down-counter with one-shot and periodic modes, sticky TIF and level irq.
//
//   clk     in   system clock, rising edge
//   rst     in   synchronous reset, active-low
//   wr_en   in   register write strobe
//   rd_en   in   register read strobe
//   addr    in   register select: 0 CTRL, 1 LOAD, 2 COUNT (RO), 3 STATUS
//   wdata   in   write data
//   rdata   out  registered read data, held until the next rd_en
//   expire  out  one-cycle pulse per expiry
//   irq     out  STATUS.TIF & CTRL.IE
// ---------------------------------------------------------------------------
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned PRESC_W = 8,
   parameter int unsigned ADDR_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              expire,
   output logic              irq
);

   state_e            state_q, state_d;
   ctrl_t             ctrl_q, ctrl_d;
   logic [DATA_W-1:0] load_q, load_d;
   logic [DATA_W-1:0] count_q, count_d;
   logic              tif_q, tif_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              expire_q, expire_d;

   logic              tick;
   logic              sel_ctrl, sel_load, sel_count, sel_status;
   logic              wr_ctrl, wr_load, wr_status;
   ctrl_t             wctrl;
   logic [DATA_W-1:0] rd_val;

   // -------------------------------------------------------------------
   // Address decode
   // -------------------------------------------------------------------
   assign sel_ctrl   = (addr == ADDR_W'(ADDR_CTRL));
   assign sel_load   = (addr == ADDR_W'(ADDR_LOAD));
   assign sel_count  = (addr == ADDR_W'(ADDR_COUNT));
   assign sel_status = (addr == ADDR_W'(ADDR_STATUS));

   assign wr_ctrl   = wr_en && sel_ctrl;
   assign wr_load   = wr_en && sel_load;
   assign wr_status = wr_en && sel_status;

   assign wctrl = ctrl_t'(wdata[CTRL_W-1:0]);

   // -------------------------------------------------------------------
   // Prescaler
   // -------------------------------------------------------------------
   timer_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .run  (state_q == ST_RUN),
      .psel (ctrl_q.psel),
      .tick (tick)
   );

   // -------------------------------------------------------------------
   // FSM, down-counter, register updates
   // -------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      load_d   = load_q;
      count_d  = count_q;
      tif_d    = tif_q;
      expire_d = 1'b0;

      if (wr_load) begin
         load_d = wdata;
      end

      // A CTRL write always lands in the register; the FSM below decides
      // whether it also starts or stops the timer.
      if (wr_ctrl) begin
         ctrl_d = wctrl;
      end

      // W1C first so that a hardware set in the same cycle overrides it.
      if (wr_status && wdata[STATUS_TIF_BIT]) begin
         tif_d = 1'b0;
      end

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (wr_ctrl && wctrl.en) begin
               state_d = ST_RUN;
               count_d = load_q;
            end
         end

         ST_RUN: begin
            if (tick) begin
               if (count_q != '0) begin
                  count_d = count_q - DATA_W'(1);
               end else begin
                  expire_d = 1'b1;
                  tif_d    = 1'b1;
                  if (ctrl_q.mode) begin
                     count_d = load_q;
                  end else begin
                     ctrl_d.en = 1'b0;
                     state_d   = ST_DONE;
                  end
               end
            end
            // A disabling write takes priority for the next state, but any
            // expiry above in the same cycle has already been committed.
            if (wr_ctrl && !wctrl.en) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------
   // Read mux (registered)
   // -------------------------------------------------------------------
   always_comb begin
      rd_val = '0;
      if (sel_ctrl) begin
         rd_val[CTRL_W-1:0] = ctrl_q;
      end else if (sel_load) begin
         rd_val = load_q;
      end else if (sel_count) begin
         rd_val = count_q;
      end else if (sel_status) begin
         rd_val[STATUS_TIF_BIT] = tif_q;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         rdata_d = rd_val;
      end
   end

   // -------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         ctrl_q   <= '0;
         load_q   <= '0;
         count_q  <= '0;
         tif_q    <= 1'b0;
         rdata_q  <= '0;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ctrl_q   <= ctrl_d;
         load_q   <= load_d;
         count_q  <= count_d;
         tif_q    <= tif_d;
         rdata_q  <= rdata_d;
         expire_q <= expire_d;
      end
   end

   assign rdata  = rdata_q;
   assign expire = expire_q;
   assign irq    = tif_q & ctrl_q.ie;

endmodule

// File: tb/tb_timer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_timer_ctrl
//   Directed self-checking bench for timer_ctrl. Inputs are driven and outputs
//   sampled on the falling edge; expiry latencies are counted in falling edges
//   after the write that precedes them.
// ---------------------------------------------------------------------------
module tb_timer_ctrl;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_LOAD   = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;
   localparam logic [1:0] A_STATUS = 2'd3;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [1:0]  addr  = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        expire;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   timer_ctrl #(
      .DATA_W  (32),
      .PRESC_W (8),
      .ADDR_W  (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .rd_en  (rd_en),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .expire (expire),
      .irq    (irq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // All helpers are entered and left on a falling edge.
   task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
      wr_en = 1'b1;
      addr  = a;
      wdata = d;
      @(negedge clk);
      wr_en = 1'b0;
      wdata = '0;
   endtask

   task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
      rd_en = 1'b1;
      addr  = a;
      @(negedge clk);
      rd_en = 1'b0;
      d     = rdata;
   endtask

   task automatic wait_expire(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (expire !== 1'b1 && n < 1000);
   endtask

   task automatic count_pulses(input int ncyc, output int p);
      p = 0;
      repeat (ncyc) begin
         @(negedge clk);
         if (expire === 1'b1) p++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          n;
      int          p;

      // ---------------- reset ----------------
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_rdata", rdata, 32'h0);
      check("rst_expire", {31'b0, expire}, 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      rst = 1'b1;
      reg_rd(A_CTRL, d);   check("rst_ctrl", d, 32'h0);
      reg_rd(A_LOAD, d);   check("rst_load", d, 32'h0);
      reg_rd(A_COUNT, d);  check("rst_count", d, 32'h0);
      reg_rd(A_STATUS, d); check("rst_status", d, 32'h0);

      // ---------------- one-shot: LOAD=3, PSEL=0 -> (3+1)*2 = 8 ----------------
      reg_wr(A_LOAD, 32'd3);
      reg_wr(A_CTRL, 32'h21);
      wait_expire(n);
      check("oneshot_latency", n, 32'd8);
      @(negedge clk);
      check("oneshot_pulse_len", {31'b0, expire}, 32'h0);
      reg_rd(A_STATUS, d); check("oneshot_tif", d, 32'h1);
      check("oneshot_irq", {31'b0, irq}, 32'h1);
      reg_rd(A_CTRL, d);   check("oneshot_ctrl_en_clr", d, 32'h20);
      count_pulses(40, p);
      check("oneshot_no_more", p, 32'd0);
      reg_wr(A_STATUS, 32'h1);
      check("oneshot_irq_clr", {31'b0, irq}, 32'h0);

      // ---------------- periodic: LOAD=1, PSEL=2 -> (1+1)*8 = 16 ----------------
      reg_wr(A_LOAD, 32'd1);
      reg_wr(A_CTRL, 32'h0B);
      wait_expire(n);
      check("per_first", n, 32'd16);
      check("per_irq_masked", {31'b0, irq}, 32'h0);
      for (int k = 0; k < 3; k++) begin
         wait_expire(n);
         check($sformatf("per_period%0d", k), n, 32'd16);
      end

      // ---------------- W1C race ----------------
      // pos 0 = falling edge just after an expiry; next expiry edge is 16 later.
      reg_wr(A_CTRL, 32'h2B);        // set IE while running: no restart
      reg_wr(A_STATUS, 32'h1);       // clear TIF ahead of the race
      repeat (13) @(negedge clk);    // now at pos 15
      reg_wr(A_STATUS, 32'h1);       // write edge coincides with the expiry
      check("race_expire_aligned", {31'b0, expire}, 32'h1);
      reg_rd(A_STATUS, d); check("race_tif_set_wins", d, 32'h1);
      check("race_irq", {31'b0, irq}, 32'h1);
      reg_wr(A_STATUS, 32'h1);
      check("race_irq_clr", {31'b0, irq}, 32'h0);
      reg_rd(A_STATUS, d); check("race_tif_clr", d, 32'h0);

      // ---------------- stop / restart: LOAD=9, PSEL=0, periodic ----------------
      reg_wr(A_CTRL, 32'h02);
      reg_wr(A_LOAD, 32'd9);
      reg_wr(A_CTRL, 32'h03);
      repeat (8) @(negedge clk);     // COUNT has reached 5 (ticks every 2 cycles)
      reg_wr(A_CTRL, 32'h02);
      reg_rd(A_COUNT, d); check("stop_count_held", d, 32'd5);
      count_pulses(30, p);
      check("stop_no_expire", p, 32'd0);
      reg_rd(A_COUNT, d); check("stop_count_still", d, 32'd5);
      reg_rd(A_CTRL, d);  check("stop_ctrl", d, 32'h02);
      reg_wr(A_CTRL, 32'h03);
      reg_rd(A_COUNT, d); check("restart_count_load", d, 32'd9);
      wait_expire(n);
      check("restart_latency", n, 32'd19);  // 20 minus the read cycle

      // ---------------- LOAD=0 periodic, PSEL=0 ----------------
      reg_wr(A_CTRL, 32'h02);
      reg_wr(A_LOAD, 32'd0);
      reg_wr(A_CTRL, 32'h03);
      wait_expire(n); check("load0_first", n, 32'd2);
      wait_expire(n); check("load0_period_a", n, 32'd2);
      wait_expire(n); check("load0_period_b", n, 32'd2);
      reg_wr(A_LOAD, 32'd2);          // COUNT untouched until next reload
      wait_expire(n); check("load2_old_reload", n, 32'd1);
      wait_expire(n); check("load2_period_a", n, 32'd6);
      wait_expire(n); check("load2_period_b", n, 32'd6);

      // ---------------- reset on an expiry edge ----------------
      repeat (5) @(negedge clk);      // pos 5; next expiry edge is pos 6
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midrst_expire", {31'b0, expire}, 32'h0);
      check("midrst_rdata", rdata, 32'h0);
      reg_rd(A_CTRL, d);   check("midrst_ctrl", d, 32'h0);
      reg_rd(A_LOAD, d);   check("midrst_load", d, 32'h0);
      reg_rd(A_COUNT, d);  check("midrst_count", d, 32'h0);
      reg_rd(A_STATUS, d); check("midrst_status", d, 32'h0);
      count_pulses(20, p);
      check("midrst_no_expire", p, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
